// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states, ASCII and line-level
// constants, and the divider clamp.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [7:0]  CR          = 8'h0D;
    localparam logic [7:0]  LF          = 8'h0A;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;
    localparam logic [31:0] MIN_DIVIDER = 32'd2;

    // Bit time in clocks; values below the minimum are raised to it.
    function automatic logic [31:0] clamp_divider(input logic [31:0] d);
        return (d < MIN_DIVIDER) ? MIN_DIVIDER : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data. Pushes while full
// and pops while empty are ignored. Pointers carry one extra wrap bit so that
// full and empty can be told apart.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes are queued in a sync_fifo and sent LSB
// first with one start and one stop bit; frames run back to back while data is
// queued. Bit time is max(cfg_divider, 2) clocks, captured at each start bit.
// ser_tx is registered from the current state, so the line trails the FSM by
// one clock.
// Optional: define UART_TX_CRLF_EN to follow every transmitted CR with an
// inserted LF frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cfg_divider,
    input  logic [7:0]  data,
    input  logic        valid,
    output logic        ready,
    output logic        ser_tx,
    output logic        busy
);

    uart_state_t state;
    uart_state_t state_nxt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [7:0]  fifo_rdata;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic [31:0] div_q;
    logic [31:0] clk_cnt;
    logic        tick;
`ifdef UART_TX_CRLF_EN
    logic        cr_pend;
    logic        load_lf;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (valid && ready),
        .wdata (data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ready = !fifo_full && !reset;
    assign busy  = !((state == IDLE) && fifo_empty);
    assign tick  = (state != IDLE) && (clk_cnt == div_q - 32'd1);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and FIFO pop; a pop always coincides with entering START.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
`ifdef UART_TX_CRLF_EN
        load_lf   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = START;
                    fifo_pop  = 1'b1;
                end
            end
            START: if (tick) state_nxt = DATA;
            DATA:  if (tick && bit_idx == 3'd7) state_nxt = STOP;
            STOP: begin
                if (tick) begin
`ifdef UART_TX_CRLF_EN
                    if (cr_pend) begin
                        state_nxt = START;
                        load_lf   = 1'b1;
                    end else if (!fifo_empty) begin
                        state_nxt = START;
                        fifo_pop  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    if (!fifo_empty) begin
                        state_nxt = START;
                        fifo_pop  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timing, divider capture, shift register and data bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt <= '0;
            div_q   <= MIN_DIVIDER;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_CRLF_EN
            cr_pend <= 1'b0;
`endif
        end else begin
            clk_cnt <= (state == IDLE || tick) ? 32'd0 : clk_cnt + 32'd1;
            if (state_nxt == START && state != START)
                div_q <= clamp_divider(cfg_divider);
            if (state == START)
                bit_idx <= 3'd0;
            if (fifo_pop) begin
                shreg <= fifo_rdata;
`ifdef UART_TX_CRLF_EN
                cr_pend <= (fifo_rdata == CR);
`endif
            end
`ifdef UART_TX_CRLF_EN
            if (load_lf) begin
                shreg   <= LF;
                cr_pend <= 1'b0;
            end
`endif
            if (state == DATA && tick) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Registered line driver; reset forces the idle level at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser_tx <= STOP_LEVEL;
        end else begin
            case (state)
                START:   ser_tx <= START_LEVEL;
                DATA:    ser_tx <= shreg[0];
                default: ser_tx <= STOP_LEVEL;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected {byte, bit time}
// frames; a line receiver pops and compares each frame seen on ser_tx.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cfg_divider = 32'd217;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic        ready;
    logic        ser_tx;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(.FIFO_DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_divider (cfg_divider),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .ser_tx      (ser_tx),
        .busy        (busy)
    );

    typedef struct {
        logic [7:0] b;
        int         d;
    } frame_t;

    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    frame_t sb[$];
    int     starts[$];
    int     last_acc = 0;
    bit     saw_full = 0;
    bit     mon_en = 1;

    // receiver state
    bit         m_act = 0;
    bit         m_prev = 1;
    int         m_k, m_d, m_bad, m_bit;
    logic [7:0] m_b, m_rx;
    logic       m_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame per accepted byte, an extra LF after CR when
    // expansion is built in; bit time is the divider raised to at least 2.
    task automatic sb_push(input logic [7:0] b, input int d);
        frame_t f;
        f.b = b;
        f.d = (d < 2) ? 2 : d;
        sb.push_back(f);
`ifdef UART_TX_CRLF_EN
        if (b == 8'h0D) begin
            f.b = 8'h0A;
            sb.push_back(f);
        end
`endif
    endtask

    // Line receiver: checks every clock of each frame against the expected
    // level and decodes the byte at mid-bit.
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            m_act  = 0;
            m_prev = 1;
        end else begin
            if (!m_act) begin
                if (m_prev && !ser_tx) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        frame_t f;
                        f = sb.pop_front();
                        m_b = f.b; m_d = f.d;
                        m_k = 0; m_bad = 0; m_rx = 8'h00; m_act = 1;
                        starts.push_back(cyc);
                    end
                end
                m_prev = ser_tx;
            end
            if (m_act) begin
                m_bit = m_k / m_d;
                m_exp = (m_bit == 0) ? 1'b0 : (m_bit == 9) ? 1'b1 : m_b[m_bit-1];
                if (ser_tx !== m_exp) m_bad++;
                if ((m_k % m_d) == (m_d / 2) && m_bit >= 1 && m_bit <= 8) m_rx[m_bit-1] = ser_tx;
                m_k++;
                if (m_k == 10 * m_d) begin
                    check("frame_byte", m_rx, m_b);
                    check("frame_timing_bad_clocks", m_bad, 0);
                    m_act  = 0;
                    m_prev = 1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit track);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready && t < 5000) begin
            valid = 1'b0;
            saw_full = 1;
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            check("send_ready_timeout", 0, 1);
            valid = 1'b0;
            return;
        end
        data  = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (track) sb_push(b, int'(cfg_divider));
    endtask

    task automatic wait_starts(input int n);
        int t;
        t = 0;
        while (starts.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("frame_start_seen", starts.size() >= n, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        valid = 1'b0;
        while ((sb.size() != 0 || m_act) && t < 30000) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending_frames", sb.size(), 0);
        repeat (3) @(negedge clk);
        check("busy_after_drain", busy, 0);
        check("ser_tx_idle_after_drain", ser_tx, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_exp, gap_bad, n, t;
        bit seen_low, idle_bad;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_ser_tx", ser_tx, 1);
        check("reset_ready", ready, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", ready, 1);

        // single frame at 217 clocks per bit, latency and busy
        cfg_divider = 32'd217;
        starts.delete();
        send(8'h41, 1);
        valid = 1'b0;
        wait_starts(1);
        if (starts.size() > 0) begin
            check("start_latency", starts[0] - last_acc, 2);
            check("busy_in_frame", busy, 1);
            while (cyc < starts[0] + 9 * 217 + 100) @(negedge clk);
            check("busy_in_stop", busy, 1);
        end
        drain();

        // back-to-back frames with FIFO overflow pressure
        cfg_divider = 32'd10;
        starts.delete();
        saw_full = 0;
        n_exp = 0;
        for (int i = 0; i < 20; i++) send(8'(i), 1);
        valid = 1'b0;
        check("ready_dropped_when_full", saw_full, 1);
        n_exp = 20;
`ifdef UART_TX_CRLF_EN
        n_exp = 21;
`endif
        drain();
        check("b2b_frame_count", starts.size(), n_exp);
        gap_bad = 0;
        for (int i = 0; i + 1 < starts.size(); i++)
            if (starts[i+1] - starts[i] != 100) gap_bad++;
        check("b2b_gaps", gap_bad, 0);

        // divider change during data bits only affects the next frame
        cfg_divider = 32'd8;
        starts.delete();
        send(8'hA5, 1);
        send(8'h3C, 0);
        valid = 1'b0;
        sb_push(8'h3C, 16);
        wait_starts(1);
        repeat (8 * 4) @(negedge clk);
        cfg_divider = 32'd16;
        drain();
        check("divider_frame_count", starts.size(), 2);
        if (starts.size() == 2) check("divider_frame1_len", starts[1] - starts[0], 80);

        // divider below minimum
        cfg_divider = 32'd0;
        for (int i = 0; i < 3; i++) send(8'($urandom), 1);
        drain();
        cfg_divider = 32'd1;
        send(8'h96, 1);
        drain();

        // CR handling
        cfg_divider = 32'd4;
        starts.delete();
        send(8'h0D, 1);
        drain();
`ifdef UART_TX_CRLF_EN
        check("cr_frame_count", starts.size(), 2);
        if (starts.size() == 2) check("crlf_gap", starts[1] - starts[0], 40);
`else
        check("cr_frame_count", starts.size(), 1);
`endif

        // randomized rounds
        for (int r = 0; r < 8; r++) begin
            cfg_divider = 32'($urandom_range(0, 12));
            n = $urandom_range(1, 18);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    valid = 1'b0;
                    repeat ($urandom_range(1, 30)) @(negedge clk);
                end
                send(($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom), 1);
            end
            drain();
        end

        // reset during the 4th data bit with 3 bytes queued
        mon_en = 0;
        cfg_divider = 32'd8;
        for (int i = 0; i < 4; i++) send(8'h55 + 8'(i), 0);
        valid = 1'b0;
        seen_low = 0;
        t = 0;
        while (!seen_low && t < 200) begin
            @(negedge clk);
            if (ser_tx === 1'b0) seen_low = 1;
            t++;
        end
        check("abort_frame_started", seen_low, 1);
        repeat (36) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_ser_tx", ser_tx, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_after_release", ready, 1);
        idle_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (ser_tx !== 1'b1 || busy !== 1'b0) idle_bad = 1;
        end
        check("abort_queue_discarded", idle_bad, 0);
        mon_en = 1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
